// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, PC step, default reset vector and
// the {pc, instr} record carried through the fetch path.
package cpu_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One fetched instruction together with the address it was fetched from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction buffer for the prefetch queue. Holds DEPTH
// {pc, instr} entries; supports simultaneous push and pop and a one-cycle
// flush that empties the queue and drops any push in the same cycle.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head_entry,
  output logic [CW-1:0] count
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  fetch_entry_t  mem_q [DEPTH];

  // Push is ignored when full and pop when empty, so a misbehaving producer
  // or consumer can never corrupt the occupancy count.
  assign push_ok = push && (count_q != CW'(DEPTH));
  assign pop_ok  = pop && (count_q != '0);

  // Next-state for pointers and occupancy; flush overrides everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write port.
  // NOTE: storage is deliberately not reset; occupancy alone decides which
  // entries are meaningful, and leaving it out keeps this a plain RAM.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head_entry = mem_q[rd_ptr_q];
  assign count      = count_q;

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue between a synchronous instruction memory and the
// core's decode stage. Issues sequential fetches while credit allows, buffers
// responses in fetch order and flushes everything on a branch redirect.
module prefetch_queue
  import cpu_pkg::*;
#(
  parameter  int              DEPTH    = 4,
  parameter  logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  localparam int              CW       = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [CW-1:0]   count
);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q,   req_pc_d;
  logic            inflight_q, inflight_d;

  logic [CW:0]     credit_used;
  logic            push, pop;
  fetch_entry_t    push_entry, head_entry;
  logic [CW-1:0]   fifo_count;

  // Credit check: queued entries plus the outstanding response must leave a
  // free slot, so the queue can never overflow. Redirect cycles and reset
  // never request.
  always_comb begin
    credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
    imem_req    = rst && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
  end

  assign imem_addr = fetch_pc_q;

  // The memory answers one cycle after the request; a redirect kills it.
  assign push       = inflight_q && !redirect_valid;
  assign push_entry = '{pc: req_pc_q, instr: imem_rdata};
  assign pop        = out_valid && out_ready;

  // Next fetch address, outstanding-request flag and its address.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = imem_req;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~32'h3;
    end else if (imem_req) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
      req_pc_d   = fetch_pc_q;
    end
  end

  // Fetch-side state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .head_entry (head_entry),
    .count      (fifo_count)
  );

  // Head outputs read zero when empty so uninitialised storage never shows.
  always_comb begin
    out_valid = (fifo_count != '0);
    out_instr = out_valid ? head_entry.instr : '0;
    out_pc    = out_valid ? head_entry.pc    : '0;
  end

  assign count = fifo_count;

endmodule

// File: tb/tb_prefetch_queue.sv
// Self-checking bench for prefetch_queue: directed phases followed by random
// out_ready / redirect traffic, compared every cycle with a queue-based model.
module tb_prefetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] MAGIC = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [2:0]  count;

  // Second instance with a reset vector near the top of the address space.
  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic [31:0] w_imem_rdata;
  logic        w_out_valid;
  logic [31:0] w_out_instr;
  logic [31:0] w_out_pc;
  logic [2:0]  w_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of fetched PCs (instr = pc ^ MAGIC), one
  // outstanding request and the next fetch address.
  logic [31:0] m_q[$];
  logic        m_inflight;
  logic [31:0] m_inflight_pc;
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .count(count)
  );

  prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .rst(rst),
    .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(w_out_valid), .out_ready(1'b1),
    .out_instr(w_out_instr), .out_pc(w_out_pc), .count(w_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_inflight    = 1'b0;
    m_inflight_pc = '0;
    m_pc          = 32'h0000_0000;
  endtask

  // One clock cycle, entered and left at a falling edge: apply inputs, check
  // all outputs against the model, advance the model, answer memory requests.
  task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
    logic        exp_req;
    logic        req_s, w_req_s;
    logic [31:0] addr_s, w_addr_s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    #1;
    exp_req = !rv && ((m_q.size() + (m_inflight ? 1 : 0)) < DEPTH);
    check("imem_req", 64'(imem_req), 64'(exp_req));
    if (exp_req) check("imem_addr", 64'(imem_addr), 64'(m_pc));
    check("count", 64'(count), 64'(m_q.size()));
    check("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      check("out_pc", 64'(out_pc), 64'(m_q[0]));
      check("out_instr", 64'(out_instr), 64'(m_q[0] ^ MAGIC));
    end
    if (rdy && m_q.size() != 0) void'(m_q.pop_front());
    if (rv) begin
      m_q.delete();
      m_inflight = 1'b0;
      m_pc       = {rpc[31:2], 2'b00};
    end else begin
      if (m_inflight) m_q.push_back(m_inflight_pc);
      m_inflight = exp_req;
      if (exp_req) begin
        m_inflight_pc = m_pc;
        m_pc          = m_pc + 32'd4;
      end
    end
    req_s    = imem_req;
    addr_s   = imem_addr;
    w_req_s  = w_imem_req;
    w_addr_s = w_imem_addr;
    @(posedge clk);
    #1;
    imem_rdata   = req_s   ? (addr_s ^ MAGIC)   : $urandom;
    w_imem_rdata = w_req_s ? (w_addr_s ^ MAGIC) : $urandom;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] w_exp [3];
    int          guard;
    w_exp[0] = 32'hFFFF_FFF8;
    w_exp[1] = 32'hFFFF_FFFC;
    w_exp[2] = 32'h0000_0000;

    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    out_ready      = 1'b0;
    imem_rdata     = '0;
    w_imem_rdata   = '0;
    model_reset();

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_imem_req", 64'(imem_req), 64'(0));
    check("rst_count", 64'(count), 64'(0));
    check("rst_out_pc", 64'(out_pc), 64'(0));
    check("rst_out_instr", 64'(out_instr), 64'(0));
    check("rst_w_out_valid", 64'(w_out_valid), 64'(0));

    // Streaming from reset with the consumer always ready; the second
    // instance shows the PC wrapping through zero.
    rst = 1'b1;
    for (int i = 0; i < 12; i++) begin
      check("w_out_valid", 64'(w_out_valid), 64'(i >= 2));
      if (i >= 2 && i <= 4) begin
        check("w_out_pc", 64'(w_out_pc), 64'(w_exp[i-2]));
        check("w_out_instr", 64'(w_out_instr), 64'(w_exp[i-2] ^ MAGIC));
      end
      step(1'b0, '0, 1'b1);
    end

    // Back-pressure: queue fills, requests stop, head holds; then drains.
    repeat (10) step(1'b0, '0, 1'b0);
    check("full_count", 64'(count), 64'(DEPTH));
    check("full_req", 64'(imem_req), 64'(0));
    repeat (8) step(1'b0, '0, 1'b1);

    // Redirect while full: flush, aligned target, first output three later.
    repeat (6) step(1'b0, '0, 1'b0);
    step(1'b1, 32'h0000_0103, 1'b0);
    check("redir_count", 64'(count), 64'(0));
    check("redir_addr", 64'(imem_addr), 64'(32'h100));
    repeat (6) step(1'b0, '0, 1'b1);

    // Redirect in steady state kills the inflight response.
    step(1'b1, 32'h0000_2000, 1'b1);
    repeat (5) step(1'b0, '0, 1'b1);

    // Back-to-back redirects: the latest one wins.
    step(1'b1, 32'h0000_3000, 1'b1);
    step(1'b1, 32'h0000_4006, 1'b0);
    repeat (6) step(1'b0, '0, 1'b1);

    // Random consumer stalls and redirects.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 8) == 0, $urandom, 1'(($urandom % 3) != 0));
    end

    // Reset mid-stream with three entries queued.
    guard = 0;
    while (m_q.size() != 3 && guard < 40) begin
      step(1'b0, '0, 1'(m_q.size() > 3));
      guard++;
    end
    check("pre_reset_count", 64'(count), 64'(3));
    rst = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'(0));
    check("mid_rst_count", 64'(count), 64'(0));
    check("mid_rst_imem_req", 64'(imem_req), 64'(0));
    check("mid_rst_out_pc", 64'(out_pc), 64'(0));
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (10) step(1'b0, '0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prefetch_queue.md
PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
Parameters (name, default, meaning):
REQ-001 DEPTH, 4, instruction queue entries; power of two, 2..16.
REQ-002 RESET_PC, 32'h0000_0000, first fetch address after reset.
Ports (name, direction, width, meaning):
REQ-003 clk  in  1  sole clock, rising-edge.
REQ-004 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-005 imem_req  out  1  fetch request to synchronous instruction memory.
REQ-006 imem_addr  out  32  byte address of request.
REQ-007 imem_rdata  in  32  instruction word; valid exactly one cycle after the imem_req cycle.
REQ-008 redirect_valid  in  1  branch/jump redirect strobe from the core.
REQ-009 redirect_pc  in  32  redirect target.
REQ-010 out_valid  out  1  queue head holds a valid instruction.
REQ-011 out_ready  in  1  core accepts head this cycle.
REQ-012 out_instr  out  32  head instruction word.
REQ-013 out_pc  out  32  head instruction address.
REQ-014 count  out  $clog2(DEPTH)+1  current queue occupancy.

Function
REQ-015 fetch_pc register: holds next fetch address; imem_addr = fetch_pc.
REQ-016 Credit rule: imem_req = 1 iff (count + inflight) < DEPTH and redirect_valid = 0; inflight = 1-bit flag, set when a request issues.
REQ-017 On issue: fetch_pc <= fetch_pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000); issued address latched as req_pc.
REQ-018 Response cycle: when inflight = 1 and not killed, {imem_rdata, req_pc} pushed at that cycle's end.
REQ-019 Pop: head removed when out_valid & out_ready; out_valid = (count != 0).
REQ-020 Simultaneous push and pop: count unchanged, both take effect; overflow impossible by REQ-016.
REQ-021 Latency: request in cycle N -> out_valid in cycle N+2; steady state with out_ready = 1 sustains 1 instruction/cycle.
REQ-022 Order: instructions leave strictly in fetch order; out_pc increments by 4 between consecutive pops unless a redirect intervened.
REQ-023 Redirect (cycle R): handshake of cycle R still completes; at end of R queue flushed (count = 0), inflight response discarded, fetch_pc <= {redirect_pc[31:2], 2'b00}; no request in cycle R.
REQ-024 After redirect: first request at target in R+1; first out_valid in R+3.
REQ-025 Back-to-back redirects: the latest one wins; each cycle of redirect_valid repeats REQ-023.
REQ-026 out_ready with out_valid = 0: no effect.
REQ-027 out_instr/out_pc hold stable while out_valid = 1 and out_ready = 0.

Reset
REQ-028 rst = 0 asynchronously clears: count = 0, pointers = 0, inflight = 0, out_valid = 0, imem_req = 0, fetch_pc = RESET_PC.
REQ-029 out_instr and out_pc read 0 during reset; queue storage need not be cleared.
REQ-030 First request (addr RESET_PC) issues in the first clock after rst deasserts; reset mid-operation discards all queued and inflight instructions.

Structure
REQ-031 Shared package cpu_pkg holds XLEN = 32, ILEN = 32, PC_STEP = 4 and default RESET_PC; prefetch_queue imports it.
REQ-032 Storage in one sub-module fetch_fifo (DEPTH x 64-bit {pc, instr}, push/pop/flush, count); credit, PC and redirect logic in prefetch_queue.
REQ-033 prefetch_queue sits between imem and cpu_core fetch; cpu_core decode consumes out_instr/out_pc.

Verification
REQ-034 Reset release, out_ready = 1, imem returns addr^32'hA5A5_0000 -> out_pc 0,4,8,... from cycle 2, one per cycle, matching instrs.
REQ-035 out_ready = 0 for 10 cycles -> count saturates at 4, imem_req drops, out_pc held 0x0; release -> 0x0,0x4,0x8,0xC then 0x10 with no gap or duplicate.
REQ-036 redirect_valid with redirect_pc = 0x103 while queue full -> count = 0 next cycle, imem_addr = 0x100, first out_pc 0x100 three cycles after redirect; no stale PC emitted.
REQ-037 Redirect in cycle of an inflight response -> that response never appears on out_instr.
REQ-038 RESET_PC = 0xFFFF_FFF8 -> out_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 rst pulsed low mid-stream (count = 3) -> out_valid = 0 immediately, refetch from RESET_PC after release.
